// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low {a..g}) and scanner state encoding.
package seg7_pkg;

   localparam int SEG_NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to BCD decoder; anything not 0-9 flags invalid.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       inv_o
);

   always_comb begin
      inv_o = 1'b0;
      case (seg_i)
         SEG_0:   bcd_o = 4'd0;
         SEG_1:   bcd_o = 4'd1;
         SEG_2:   bcd_o = 4'd2;
         SEG_3:   bcd_o = 4'd3;
         SEG_4:   bcd_o = 4'd4;
         SEG_5:   bcd_o = 4'd5;
         SEG_6:   bcd_o = 4'd6;
         SEG_7:   bcd_o = 4'd7;
         SEG_8:   bcd_o = 4'd8;
         SEG_9:   bcd_o = 4'd9;
         default: begin
            bcd_o = 4'hF;
            inv_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed 7-segment scanner: frame-start snapshot of the segment bus,
// blank/drive digit sequencing, leading-zero blanking and BCD readback.
module seg_display_scanner
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = SEG_NUM_DIGITS,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 8
) (
   input  logic                       sys_clk,
   input  logic                       rst,
   input  logic [NUM_DIGITS-1:0][6:0] seg_in,
   input  logic                       scan_en,
   input  logic                       lz_blank_en,
   output logic [6:0]                 seg_out,
   output logic [NUM_DIGITS-1:0]      dig_sel_n,
   output logic [NUM_DIGITS-1:0][3:0] bcd_out,
   output logic                       bcd_valid,
   output logic                       seg_err
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   scan_state_e               state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0][6:0] snap_q, snap_d, seg_prev_q;
   logic                      cap_done_q, cap_done_d, cap, cap_q, frame_start;
   logic [6:0]                seg_q, seg_d;
   logic [NUM_DIGITS-1:0]     dig_q, dig_d, lz, dec_inv;
   logic [NUM_DIGITS-1:0][3:0] dec_bcd, bcd_q;
   logic                      vld_q, err_q;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      seg7_decode u_dec (
         .seg_i (snap_q[g]),
         .bcd_o (dec_bcd[g]),
         .inv_o (dec_inv[g])
      );
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (!scan_en) begin
         state_d = S_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_BLANK;
               idx_d   = '0;
               cnt_d   = '0;
            end
            S_BLANK: begin
               if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                  state_d = S_DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_DRIVE: begin
               if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
                  idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Snapshot only a bus that held still for two cycles, at most once per frame start.
   always_comb begin
      frame_start = (state_q == S_BLANK) && (idx_q == '0);
      cap         = frame_start && !cap_done_q && (seg_in == seg_prev_q);
      cap_done_d  = frame_start && (cap_done_q || cap);
      snap_d      = cap ? seg_in : snap_q;
   end

   always_comb begin
      logic zero_run;
      lz       = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run = zero_run && (snap_d[i] == SEG_0);
         lz[i]    = lz_blank_en && zero_run;
      end
   end

   // Outputs are registered from next-state so they line up with the state they show.
   always_comb begin
      seg_d = SEG_BLANK;
      dig_d = '1;
      if (state_d == S_DRIVE) begin
         dig_d[idx_d] = 1'b0;
         seg_d        = lz[idx_d] ? SEG_BLANK : snap_d[idx_d];
      end
   end

   always_ff @(posedge sys_clk) begin
      seg_prev_q <= seg_in;
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         cap_done_q <= 1'b0;
         cap_q      <= 1'b0;
         snap_q     <= {NUM_DIGITS{SEG_0}};
         seg_q      <= SEG_BLANK;
         dig_q      <= '1;
         bcd_q      <= '0;
         vld_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         cap_done_q <= cap_done_d;
         cap_q      <= cap;
         snap_q     <= snap_d;
         seg_q      <= seg_d;
         dig_q      <= dig_d;
         vld_q      <= cap_q;
         err_q      <= cap_q && (|dec_inv);
         if (cap_q) bcd_q <= dec_bcd;
      end
   end

   assign seg_out   = seg_q;
   assign dig_sel_n = dig_q;
   assign bcd_out   = bcd_q;
   assign bcd_valid = vld_q;
   assign seg_err   = err_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Randomised bench for seg_display_scanner against a frame-arithmetic reference model.
module tb_seg_display_scanner;

   localparam int N  = 6;
   localparam int D  = 4;
   localparam int B  = 2;
   localparam int P  = B + D;
   localparam int FR = N * P;

   logic                sys_clk = 1'b0;
   logic                rst = 1'b1;
   logic                scan_en = 1'b0;
   logic                lz_blank_en = 1'b0;
   logic [N-1:0][6:0]   seg_in;
   logic [6:0]          seg_out;
   logic [N-1:0]        dig_sel_n;
   logic [N-1:0][3:0]   bcd_out;
   logic                bcd_valid, seg_err;

   int tests = 0;
   int fails = 0;

   logic [6:0] SEGS [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   always #5 sys_clk = ~sys_clk;

   seg_display_scanner #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .scan_en     (scan_en),
      .lz_blank_en (lz_blank_en),
      .seg_out     (seg_out),
      .dig_sel_n   (dig_sel_n),
      .bcd_out     (bcd_out),
      .bcd_valid   (bcd_valid),
      .seg_err     (seg_err)
   );

   function automatic logic [3:0] dec(input logic [6:0] p);
      for (int k = 0; k < 10; k++) if (p == SEGS[k]) return 4'(k);
      return 4'hF;
   endfunction

   function automatic logic [6:0] rpat();
      if ($urandom % 16 == 0) return 7'b1111110;
      return SEGS[$urandom % 10];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: position in the scan is plain arithmetic on cycles since scan start.
   bit                m_act = 0, m_pend = 0, m_done = 0, m_vld = 0, m_err = 0, chk_on = 0;
   int                m_t = 0;
   logic [N-1:0][6:0] m_snap, m_prev;
   logic [N-1:0][3:0] m_bcd;
   logic [6:0]        e_seg;
   logic [N-1:0]      e_dig;

   always @(posedge sys_clk) begin : model
      int  slot, idx, off;
      bit  zr;
      if (rst) begin
         m_act = 0; m_t = 0; m_pend = 0; m_done = 0; m_vld = 0; m_err = 0;
         m_bcd = '0;
         for (int i = 0; i < N; i++) m_snap[i] = SEGS[0];
         chk_on = 1;
      end else begin
         m_vld = m_pend;
         m_err = 0;
         if (m_pend)
            for (int i = 0; i < N; i++) begin
               m_bcd[i] = dec(m_snap[i]);
               if (m_bcd[i] == 4'hF) m_err = 1;
            end
         m_pend = 0;
         if (m_act) begin
            slot = m_t % FR; idx = slot / P; off = slot % P;
            if (idx == 0 && off < B) begin
               if (!m_done && seg_in == m_prev) begin
                  m_snap = seg_in; m_pend = 1; m_done = 1;
               end
            end else m_done = 0;
         end else m_done = 0;
         if (!scan_en) m_act = 0;
         else if (!m_act) begin m_act = 1; m_t = 0; end
         else m_t++;
      end
      m_prev = seg_in;
      e_seg = 7'h7F;
      e_dig = '1;
      if (m_act) begin
         slot = m_t % FR; idx = slot / P; off = slot % P;
         if (off >= B) begin
            e_dig[idx] = 1'b0;
            zr = 1;
            for (int j = idx; j < N; j++) if (m_snap[j] != SEGS[0]) zr = 0;
            e_seg = (lz_blank_en && idx > 0 && zr) ? 7'h7F : m_snap[idx];
         end
      end
   end

   always @(negedge sys_clk) begin
      if (chk_on) begin
         chk("seg_out", seg_out, e_seg);
         chk("dig_sel_n", dig_sel_n, e_dig);
         chk("bcd_out", bcd_out, m_bcd);
         chk("bcd_valid", bcd_valid, m_vld);
         chk("seg_err", seg_err, m_err);
         chk("dig_onehot", ($countones(~dig_sel_n) > 1), 0);
      end
   end

   task automatic set6(input int d5, input int d4, input int d3,
                       input int d2, input int d1, input int d0);
      int d [N];
      d = '{d0, d1, d2, d3, d4, d5};
      for (int i = 0; i < N; i++) seg_in[i] = (d[i] < 0) ? 7'b1111110 : SEGS[d[i]];
   endtask

   task automatic wait_valid(input string nm);
      int k = 0;
      do begin @(negedge sys_clk); k++; end while (!bcd_valid && k < 200);
      chk(nm, bcd_valid, 1);
   endtask

   task automatic wait_dig(input logic [N-1:0] pat, input string nm);
      int k = 0;
      do begin @(negedge sys_clk); k++; end while (dig_sel_n !== pat && k < 200);
      chk(nm, dig_sel_n, pat);
   endtask

   initial begin
      int nv;
      set6(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_seg", seg_out, 7'b1111111);
      chk("rst_dig", dig_sel_n, 6'b111111);
      chk("rst_bcd", bcd_out, 24'h0);
      chk("rst_vld", bcd_valid, 0);
      rst = 1'b0;

      // all zeros, scanning
      scan_en = 1'b1;
      wait_valid("s1_valid");
      chk("s1_bcd", bcd_out, 24'h000000);
      wait_dig(6'b111110, "s1_dig0");
      chk("s1_seg0", seg_out, 7'b0000001);

      // 12:34:56
      set6(1, 2, 3, 4, 5, 6);
      wait_valid("s2_valid");
      chk("s2_bcd", bcd_out, 24'h123456);
      wait_dig(6'b011111, "s2_dig5");
      chk("s2_seg5", seg_out, 7'b1001111);

      // 00:05:09 with leading-zero blanking
      lz_blank_en = 1'b1;
      set6(0, 0, 0, 5, 0, 9);
      wait_valid("s3_valid");
      wait_dig(6'b111110, "s3_dig0"); chk("s3_seg0", seg_out, 7'b0000100);
      wait_dig(6'b111101, "s3_dig1"); chk("s3_seg1", seg_out, 7'b0000001);
      wait_dig(6'b111011, "s3_dig2"); chk("s3_seg2", seg_out, 7'b0100100);
      wait_dig(6'b110111, "s3_dig3"); chk("s3_seg3", seg_out, 7'b1111111);
      wait_dig(6'b101111, "s3_dig4"); chk("s3_seg4", seg_out, 7'b1111111);
      wait_dig(6'b011111, "s3_dig5"); chk("s3_seg5", seg_out, 7'b1111111);

      // invalid pattern on digit 2
      lz_blank_en = 1'b0;
      set6(9, 8, 7, -1, 6, 5);
      wait_valid("s4_valid");
      chk("s4_bcd", bcd_out, 24'h987F65);
      chk("s4_err", seg_err, 1);

      // bus toggling every cycle: no capture may happen
      nv = 0;
      for (int k = 0; k < 3 * FR; k++) begin
         if (k % 2 == 0) set6(3, 3, 3, 3, 3, 3); else set6(8, 8, 8, 8, 8, 8);
         @(negedge sys_clk);
         nv += int'(bcd_valid);
      end
      chk("tog_novalid", nv, 0);
      chk("tog_bcd_held", bcd_out, 24'h987F65);

      // scan_en dropped mid-DRIVE
      set6(4, 4, 4, 4, 4, 4);
      wait_dig(6'b111011, "drop_drive");
      scan_en = 1'b0;
      @(negedge sys_clk);
      chk("drop_idle", dig_sel_n, 6'b111111);
      scan_en = 1'b1;

      // random traffic
      for (int k = 0; k < 1500; k++) begin
         @(posedge sys_clk); #1;
         if ($urandom % 8 == 0) for (int i = 0; i < N; i++) seg_in[i] = rpat();
         if ($urandom % 32 == 0) lz_blank_en = ~lz_blank_en;
         scan_en = ($urandom % 50 != 0);
         rst = ($urandom % 300 == 0);
      end
      rst = 1'b0;
      scan_en = 1'b1;

      // reset in the middle of DRIVE
      wait_dig(6'b111101, "mid_drive");
      rst = 1'b1;
      @(negedge sys_clk);
      chk("mrst_dig", dig_sel_n, 6'b111111);
      chk("mrst_seg", seg_out, 7'b1111111);
      chk("mrst_bcd", bcd_out, 24'h0);
      chk("mrst_vld", bcd_valid, 0);
      rst = 1'b0;
      repeat (4) @(negedge sys_clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
